// File: rtl/regbank_write_arbiter_if.sv
// Bundle of requester, write-port, read-forwarding and status signals for regbank_write_arbiter.
// master = requesters/bank side, slave = the arbiter.
interface regbank_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] bank_dout1;
    logic [DATA_W-1:0] bank_dout2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data,
        output rd_addr1, rd_addr2, bank_dout1, bank_dout2,
        input  rd_data1, rd_data2, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data,
        input  rd_addr1, rd_addr2, bank_dout1, bank_dout2,
        output rd_data1, rd_data2, conflict_cnt
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between ALU (req0) and load unit (req1),
// with a registered write stage, read forwarding and a saturating conflict counter.
// Optional macro REGBANK_ZERO_PROTECT_EN: accepted writes to register 0 are handshaken but discarded.
module regbank_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    regbank_write_arbiter_if.slave bus
);
    logic              prio_q,    prio_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              drop_write;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign accept   = grant0 | grant1;
    assign gnt_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    assign gnt_data = grant1 ? bus.req1_data : bus.req0_data;

`ifdef REGBANK_ZERO_PROTECT_EN
    assign drop_write = (gnt_addr == '0);
`else
    assign drop_write = 1'b0;
`endif

    always_comb begin
        prio_d    = prio_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        if (accept) begin
            // The winner loses priority; a dropped zero-register write still counts as a turn.
            prio_d  = grant0;
            wr_en_d = !drop_write;
            if (!drop_write) begin
                wr_addr_d = gnt_addr;
                wr_data_d = gnt_data;
            end
        end
        if (bus.req0_valid && bus.req1_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.conflict_cnt = cnt_q;

    // Forwarding covers the cycle between write-port drive and bank commit.
    logic [ADDR_W-1:0] rd_addr_w [2];
    logic [DATA_W-1:0] dout_w    [2];
    logic [DATA_W-1:0] rd_data_w [2];
    logic              fwd_ok;

    assign rd_addr_w[0] = bus.rd_addr1;
    assign rd_addr_w[1] = bus.rd_addr2;
    assign dout_w[0]    = bus.bank_dout1;
    assign dout_w[1]    = bus.bank_dout2;

`ifdef REGBANK_ZERO_PROTECT_EN
    assign fwd_ok = wr_en_q && (wr_addr_q != '0);
`else
    assign fwd_ok = wr_en_q;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign rd_data_w[gi] = (fwd_ok && (rd_addr_w[gi] == wr_addr_q)) ? wr_data_q : dout_w[gi];
        end
    endgenerate

    assign bus.rd_data1 = rd_data_w[0];
    assign bus.rd_data2 = rd_data_w[1];
endmodule
